// File: rtl/fir_pkg.sv
// Shared FIR datapath types: default sizes, sample/window typedefs and the
// tap-buffer control state encoding.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_TAPS   = 8;
  localparam int NUM_CH     = 2;
  localparam int DECIM_W    = 4;

  typedef logic [DATA_WIDTH-1:0] sample_t;
  // Index 0 is the newest sample, NUM_TAPS-1 the oldest.
  typedef sample_t   [NUM_TAPS-1:0] chan_win_t;
  typedef chan_win_t [NUM_CH-1:0]   window_t;

  typedef enum logic {
    FILLING   = 1'b0,
    STREAMING = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/tap_decim_ctrl.sv
// Fill/decimation control for the tap window buffer: counts valid taps,
// tracks the decimation phase once full and flags accepts that emit a window.
module tap_decim_ctrl #(
  parameter int NUM_TAPS = 8,
  parameter int DECIM_W  = 4,
  parameter int CNT_W    = $clog2(NUM_TAPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               accept,
  input  logic [DECIM_W-1:0] decim,
  output logic [CNT_W-1:0]   fill_count,
  output logic               emit
);
  import fir_pkg::*;

  ctrl_state_t        state;
  logic [DECIM_W-1:0] phase;
  logic [DECIM_W-1:0] eff;
  logic [DECIM_W:0]   phase_next;
  logic               last_fill;

  // Decide whether the current accept completes a window.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    eff        = (decim == '0) ? DECIM_W'(1) : decim;
    phase_next = {1'b0, phase} + 1'b1;
    last_fill  = (fill_count == CNT_W'(NUM_TAPS - 1));
    emit       = 1'b0;
    if (accept) begin
      if (state == FILLING) emit = last_fill;
      // ">=" also catches a phase left beyond a freshly lowered decim.
      else                  emit = (phase_next >= {1'b0, eff});
    end
  end

  // Fill counter, phase counter and FILLING/STREAMING state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state      <= FILLING;
      fill_count <= '0;
      phase      <= '0;
    end else if (accept) begin
      if (state == FILLING) begin
        fill_count <= fill_count + 1'b1;
        phase      <= '0;
        if (last_fill) state <= STREAMING;
      end else begin
        phase <= emit ? '0 : phase_next[DECIM_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tap_window_buffer.sv
// Multi-channel tap delay line presenting the last NUM_TAPS samples of each
// channel as a parallel window, with valid/ready handshakes on both sides,
// fill tracking, runtime decimation and synchronous flush.
module tap_window_buffer #(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int NUM_TAPS   = fir_pkg::NUM_TAPS,
  parameter int NUM_CH     = fir_pkg::NUM_CH,
  parameter int DECIM_W    = fir_pkg::DECIM_W,
  parameter int CNT_W      = $clog2(NUM_TAPS + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0]         in_data,
  input  logic [DECIM_W-1:0]                   decim,
  input  logic                                 flush,
  output logic                                 win_valid,
  input  logic                                 win_ready,
  output logic [NUM_CH*NUM_TAPS*DATA_WIDTH-1:0] win_data,
  output logic [CNT_W-1:0]                     fill_count
);
  import fir_pkg::*;

  // taps[c][k]: channel c, tap k (0 = newest). Packed so the flat port
  // layout is element (c*NUM_TAPS + k) of DATA_WIDTH bits.
  logic [NUM_CH-1:0][NUM_TAPS-1:0][DATA_WIDTH-1:0] taps;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]               in_samples;
  logic                                            accept;
  logic                                            emit;

  assign in_samples = in_data;
  // Combinational from win_ready: a taken window frees the taps this cycle.
  assign in_ready   = !flush && (!win_valid || win_ready);
  assign accept     = in_valid && in_ready;
  assign win_data   = taps;

  tap_decim_ctrl #(
    .NUM_TAPS (NUM_TAPS),
    .DECIM_W  (DECIM_W),
    .CNT_W    (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .accept     (accept),
    .decim      (decim),
    .fill_count (fill_count),
    .emit       (emit)
  );

  // Shift every channel by one tap on each accepted sample set.
  // NOTE: the tap array is reset because a flushed or reset window must read
  // as zeros; that costs a reset on every tap flop, which is intended here.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      taps <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        taps[c] <= {taps[c][NUM_TAPS-2:0], in_samples[c]};
      end
    end
  end

  // Window valid: set by an emitting accept, cleared by a take without emit.
  always_ff @(posedge clk) begin
    if (rst || flush)   win_valid <= 1'b0;
    else if (emit)      win_valid <= 1'b1;
    else if (win_ready) win_valid <= 1'b0;
  end

endmodule

// File: tb/tb_tap_window_buffer.sv
// Directed self-checking bench for tap_window_buffer: fill, decimation,
// decim=0, backpressure, flush mid-fill and reset while streaming.
module tb_tap_window_buffer;
  import fir_pkg::*;

  localparam int CNT_W = $clog2(NUM_TAPS + 1);

  logic                                  clk = 1'b0;
  logic                                  rst;
  logic                                  in_valid;
  logic                                  in_ready;
  logic [NUM_CH*DATA_WIDTH-1:0]          in_data;
  logic [DECIM_W-1:0]                    decim;
  logic                                  flush;
  logic                                  win_valid;
  logic                                  win_ready;
  logic [NUM_CH*NUM_TAPS*DATA_WIDTH-1:0] win_data;
  logic [CNT_W-1:0]                      fill_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  tap_window_buffer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .decim      (decim),
    .flush      (flush),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .fill_count (fill_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] tap(input int c, input int k);
    window_t w;
    w = win_data;
    return 64'(w[c][k]);
  endfunction

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample set; it must be accepted at the next edge.
  task automatic push(input int s0, input int s1);
    in_valid = 1'b1;
    in_data  = {16'(s1), 16'(s0)};
    #1;
    check("push_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_window(input string tag, input int newest0, input int newest1);
    for (int k = 0; k < NUM_TAPS; k++) begin
      check({tag, "_ch0"}, tap(0, k), 64'(newest0 - k));
      check({tag, "_ch1"}, tap(1, k), 64'(newest1 - k));
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_fill"}, 64'(fill_count), 64'd0);
    check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
    check({tag, "_win_data"}, 64'(win_data == '0), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; decim = 4'd1;
    flush = 1'b0; win_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    check_cleared("reset");
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Fill with decim=1.
    for (int i = 1; i <= 8; i++) begin
      push(i, 100 + i);
      check("fill_count", 64'(fill_count), 64'(i));
      check("fill_win_valid", 64'(win_valid), 64'(i == 8));
    end
    check_window("fill_window", 8, 108);
    step();
    check("take_clears_valid", 64'(win_valid), 64'd0);

    // decim=3: windows after samples 11 and 14 only.
    decim = 4'd3;
    for (int i = 9; i <= 16; i++) begin
      push(i, 100 + i);
      check("decim3_win_valid", 64'(win_valid), 64'(i == 11 || i == 14));
      if (i == 11 || i == 14) check("decim3_newest", tap(0, 0), 64'(i));
      check("decim3_fill", 64'(fill_count), 64'd8);
    end

    // decim=0 behaves as 1; phase is 2 here, so the first accept also
    // exercises the phase-beyond-decim case.
    decim = 4'd0;
    for (int i = 17; i <= 19; i++) begin
      push(i, 100 + i);
      check("decim0_win_valid", 64'(win_valid), 64'd1);
      check("decim0_newest", tap(0, 0), 64'(i));
    end

    // Backpressure: window for 19 pending, sample 20 offered.
    win_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {16'd120, 16'd20};
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_newest", tap(0, 0), 64'd19);
      check("bp_oldest", tap(1, NUM_TAPS - 1), 64'd112);
      check("bp_win_valid", 64'(win_valid), 64'd1);
      step();
    end
    win_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check("bp_release_newest", tap(0, 0), 64'd20);
    check("bp_release_win_valid", 64'(win_valid), 64'd1);
    check_window("bp_release_window", 20, 120);

    // Flush clears a full buffer; a flush-cycle sample is refused.
    decim    = 4'd1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {16'd199, 16'd99};
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_cleared("flush_full");

    // Flush mid-fill after 5 accepts.
    for (int i = 1; i <= 5; i++) push(i, 100 + i);
    check("midfill_count", 64'(fill_count), 64'd5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = {16'd177, 16'd77};
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_cleared("flush_midfill");
    for (int i = 31; i <= 38; i++) begin
      push(i, 100 + i);
      check("refill_win_valid", 64'(win_valid), 64'(i == 38));
    end
    check_window("refill_window", 38, 138);

    // Reset while streaming with a window pending and a sample offered.
    check("pre_rst_win_valid", 64'(win_valid), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = {16'd155, 16'd55};
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_cleared("rst_stream");
    check("rst_stream_in_ready", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
